// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: decodes instrCode and sequences the
// DataPath control inputs through Fetch/Decode/Execute/MemAcc/WriteBack.
module multicycle_control_unit #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  output logic        PCEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        busWe,
  output logic        illegalInstr
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_L  = 7'b0000011;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [2:0] WD_ALU  = 3'd0;
  localparam logic [2:0] WD_LOAD = 3'd1;
  localparam logic [2:0] WD_IMM  = 3'd2;
  localparam logic [2:0] WD_AUI  = 3'd3;
  localparam logic [2:0] WD_PC4  = 3'd4;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);
  localparam logic [3:0] CNT_MAX   = 4'hF;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    R_EXE,
    I_EXE,
    LU_EXE,
    AU_EXE,
    B_EXE,
    J_EXE,
    JL_EXE,
    S_EXE,
    S_MEM,
    L_EXE,
    L_MEM,
    L_WB
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       mem_done;

  assign opcode   = instrCode[6:0];
  assign funct3   = instrCode[14:12];
  assign f7b5     = instrCode[30];
  assign mem_done = (cnt_q == WAIT_LAST);

  // State and wait-counter registers; reset aborts any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state selection from current state and opcode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        unique case (opcode)
          OP_R:    state_d = R_EXE;
          OP_I:    state_d = I_EXE;
          OP_LU:   state_d = LU_EXE;
          OP_AU:   state_d = AU_EXE;
          OP_B:    state_d = B_EXE;
          OP_J:    state_d = J_EXE;
          OP_JL:   state_d = JL_EXE;
          OP_S:    state_d = S_EXE;
          OP_L:    state_d = L_EXE;
          default: state_d = FETCH;
        endcase
      end
      R_EXE,
      I_EXE,
      LU_EXE,
      AU_EXE,
      B_EXE,
      J_EXE,
      JL_EXE: state_d = FETCH;
      S_EXE:  state_d = S_MEM;
      S_MEM:  state_d = mem_done ? FETCH : S_MEM;
      L_EXE:  state_d = L_MEM;
      L_MEM:  state_d = mem_done ? L_WB : L_MEM;
      L_WB:   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Wait counter: zero on every state entry, saturating while held.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Moore control outputs; forced to idle values while reset is held.
  always_comb begin
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluControl    = ALU_ADD;
    aluSrcMuxSel  = 1'b0;
    RFWDSrcMuxSel = WD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    busWe         = 1'b0;
    illegalInstr  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        FETCH: PCEn = 1'b1;
        DECODE: begin
          unique case (opcode)
            OP_R, OP_I, OP_LU, OP_AU, OP_B,
            OP_J, OP_JL, OP_S, OP_L: illegalInstr = 1'b0;
            default: illegalInstr = 1'b1;
          endcase
        end
        R_EXE: begin
          aluControl    = {f7b5, funct3};
          aluSrcMuxSel  = 1'b0;
          RFWDSrcMuxSel = WD_ALU;
          regFileWe     = 1'b1;
        end
        I_EXE: begin
          aluControl    = (funct3 == 3'b101) ?
                          {f7b5, funct3} :
                          {1'b0, funct3};
          aluSrcMuxSel  = 1'b1;
          RFWDSrcMuxSel = WD_ALU;
          regFileWe     = 1'b1;
        end
        LU_EXE: begin
          RFWDSrcMuxSel = WD_IMM;
          regFileWe     = 1'b1;
        end
        AU_EXE: begin
          RFWDSrcMuxSel = WD_AUI;
          jalr          = 1'b0;
          regFileWe     = 1'b1;
        end
        B_EXE: begin
          aluControl   = {1'b0, funct3};
          aluSrcMuxSel = 1'b0;
          branch       = 1'b1;
        end
        J_EXE: begin
          jal           = 1'b1;
          jalr          = 1'b0;
          RFWDSrcMuxSel = WD_PC4;
          regFileWe     = 1'b1;
        end
        JL_EXE: begin
          jal           = 1'b1;
          jalr          = 1'b1;
          RFWDSrcMuxSel = WD_PC4;
          regFileWe     = 1'b1;
        end
        S_EXE: begin
          aluControl   = ALU_ADD;
          aluSrcMuxSel = 1'b1;
        end
        S_MEM: busWe = 1'b1;
        L_EXE: begin
          aluControl   = ALU_ADD;
          aluSrcMuxSel = 1'b1;
        end
        L_MEM: busWe = 1'b0;
        L_WB: begin
          RFWDSrcMuxSel = WD_LOAD;
          regFileWe     = 1'b1;
        end
        default: PCEn = 1'b0;
      endcase
    end
  end

endmodule
